// File: rtl/root_r839304.sv
// Sequential evaluator of RES = IN0 + IN1*IN2 + IN3^IN4 (mod 2^WIDTH).
// Multiply by repeated addition, power by repeated multiplication.
module root_r839304 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             RST,
    input  logic             ST,
    input  logic             CLK,
    output logic             RD,
    output logic [WIDTH-1:0] RES,
    input  logic [WIDTH-1:0] IN0,
    input  logic [WIDTH-1:0] IN1,
    input  logic [WIDTH-1:0] IN2,
    input  logic [WIDTH-1:0] IN3,
    input  logic [WIDTH-1:0] IN4
);

    typedef enum logic [1:0] {IDLE, MUL, POW, DONE} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] a0, a1, a3, a4;
    logic [WIDTH-1:0] a0_d, a1_d, a3_d, a4_d;
    logic [WIDTH-1:0] p, q, cnt;
    logic [WIDTH-1:0] p_d, q_d, cnt_d;
    logic [WIDTH-1:0] res_d;
    logic             rd_d;

    always_comb begin
        state_d = state;
        a0_d    = a0;
        a1_d    = a1;
        a3_d    = a3;
        a4_d    = a4;
        p_d     = p;
        q_d     = q;
        cnt_d   = cnt;
        res_d   = RES;
        rd_d    = RD;
        case (state)
            IDLE, DONE: begin
                if (ST) begin
                    a0_d    = IN0;
                    a1_d    = IN1;
                    a3_d    = IN3;
                    a4_d    = IN4;
                    p_d     = '0;
                    cnt_d   = IN2;
                    rd_d    = 1'b0;
                    state_d = MUL;
                end
            end
            MUL: begin
                if (cnt == '0) begin
                    q_d     = WIDTH'(1);
                    cnt_d   = a4;
                    state_d = POW;
                end else begin
                    p_d   = p + a1;
                    cnt_d = cnt - WIDTH'(1);
                end
            end
            POW: begin
                if (cnt == '0) begin
                    res_d   = a0 + p + q;
                    rd_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    q_d   = q * a3;
                    cnt_d = cnt - WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            a0    <= '0;
            a1    <= '0;
            a3    <= '0;
            a4    <= '0;
            p     <= '0;
            q     <= '0;
            cnt   <= '0;
            RES   <= '0;
            RD    <= 1'b0;
        end else begin
            state <= state_d;
            a0    <= a0_d;
            a1    <= a1_d;
            a3    <= a3_d;
            a4    <= a4_d;
            p     <= p_d;
            q     <= q_d;
            cnt   <= cnt_d;
            RES   <= res_d;
            RD    <= rd_d;
        end
    end

endmodule

// File: tb/tb_root_r839304.sv
// Randomized self-checking bench for root_r839304 against a closed-form model.
module tb_root_r839304;

    logic        RST, ST, CLK, RD;
    logic [15:0] RES, IN0, IN1, IN2, IN3, IN4;
    int          n_checks = 0;
    int          n_pass   = 0;

    root_r839304 #(.WIDTH(16)) dut (
        .RST(RST), .ST(ST), .CLK(CLK), .RD(RD), .RES(RES),
        .IN0(IN0), .IN1(IN1), .IN2(IN2), .IN3(IN3), .IN4(IN4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic [15:0] model(input logic [15:0] a0, a1, a2, a3, a4);
        logic [15:0] pw;
        pw = 16'd1;
        for (int unsigned i = 0; i < a4; i++) pw = pw * a3;
        return a0 + a1 * a2 + pw;
    endfunction

    // Start from IDLE/DONE, count edges to RD, then confirm RD/RES hold.
    task automatic run_op(input logic [15:0] a0, a1, a2, a3, a4, input bit scramble, input string tag);
        logic [15:0] expv, prev_res;
        int          lat, k;
        bit          held;
        expv = model(a0, a1, a2, a3, a4);
        lat  = int'(a2) + int'(a4) + 2;
        @(negedge CLK);
        IN0 = a0; IN1 = a1; IN2 = a2; IN3 = a3; IN4 = a4; ST = 1'b1;
        @(posedge CLK); #1;
        check({tag, "_rd_clr"}, {31'd0, RD}, 32'd0);
        prev_res = RES;
        held = 1'b1;
        k = 0;
        while (k < lat + 5) begin
            @(negedge CLK);
            if (scramble) begin
                IN0 = 16'($urandom); IN1 = 16'($urandom); IN2 = 16'($urandom);
                IN3 = 16'($urandom); IN4 = 16'($urandom); ST = 1'($urandom);
            end else ST = 1'b0;
            @(posedge CLK); #1;
            k++;
            if (RD) break;
            if (RES !== prev_res) held = 1'b0;
        end
        check({tag, "_lat"}, k, lat);
        check({tag, "_res"}, {16'd0, RES}, {16'd0, expv});
        check({tag, "_res_stable"}, {31'd0, held}, 32'd1);
        @(negedge CLK);
        ST = 1'b0;
        IN0 = 16'($urandom);
        repeat (3) @(posedge CLK);
        #1;
        check({tag, "_hold"}, {15'd0, RD, RES}, {15'd0, 1'b1, expv});
    endtask

    initial begin
        bit quiet;
        RST = 1'b1; ST = 1'b0;
        IN0 = '0; IN1 = '0; IN2 = '0; IN3 = '0; IN4 = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset", {15'd0, RD, RES}, 32'd0);
        @(negedge CLK); RST = 1'b0;

        run_op(16'd2, 16'd3, 16'd3, 16'd2, 16'd3, 1'b0, "basic");
        run_op(16'd5, 16'd7, 16'd0, 16'd9, 16'd0, 1'b0, "zero_pow");
        run_op(16'hFFFF, 16'd1, 16'd1, 16'd2, 16'd0, 1'b0, "wrap");
        run_op(16'd0, 16'h1234, 16'd0, 16'd2, 16'd16, 1'b0, "pow_ovf");

        // Reset mid-MUL aborts and clears outputs.
        @(negedge CLK);
        IN0 = 16'd2; IN1 = 16'd3; IN2 = 16'd3; IN3 = 16'd2; IN4 = 16'd3; ST = 1'b1;
        @(posedge CLK);
        @(negedge CLK); ST = 1'b0;
        @(posedge CLK);
        @(negedge CLK); RST = 1'b1;
        @(posedge CLK); #1;
        check("rst_mid_mul", {15'd0, RD, RES}, 32'd0);
        @(negedge CLK); RST = 1'b0;
        run_op(16'd2, 16'd3, 16'd3, 16'd2, 16'd3, 1'b0, "after_rst");

        // Reset mid-POW with ST on the same edge: no result may ever appear.
        @(negedge CLK);
        IN0 = 16'd1; IN1 = 16'd1; IN2 = 16'd0; IN3 = 16'd3; IN4 = 16'd6; ST = 1'b1;
        @(posedge CLK);
        @(negedge CLK); ST = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK); RST = 1'b1; ST = 1'b1;
        @(posedge CLK); #1;
        check("rst_mid_pow", {15'd0, RD, RES}, 32'd0);
        @(negedge CLK); RST = 1'b0; ST = 1'b0;
        quiet = 1'b1;
        repeat (12) begin
            @(posedge CLK); #1;
            if (RD) quiet = 1'b0;
        end
        check("rst_prio_no_rd", {31'd0, quiet}, 32'd1);

        run_op(16'd10, 16'd4, 16'd5, 16'd3, 16'd4, 1'b1, "scramble");
        run_op(16'd7, 16'd2, 16'd2, 16'd5, 16'd2, 1'b0, "restart_done");

        for (int i = 0; i < 20; i++)
            run_op(16'($urandom), 16'($urandom), 16'($urandom_range(0, 20)),
                   16'($urandom), 16'($urandom_range(0, 20)), 1'($urandom), "rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/root_r839304.md
ROOT_R839304 -- requirements
Module: root_r839304

Interface
REQ-001 Parameter: WIDTH, default 16, data width of IN0..IN4, RES and all internal arithmetic.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 ST  input  1  start request, level-sampled on rising CLK edge.
REQ-005 RD  output  1  ready: result valid, registered.
REQ-006 RES  output  WIDTH  result, registered.
REQ-007 IN0, IN1, IN2, IN3, IN4  input  WIDTH each  operands.
REQ-008 Port order SHALL be RST, ST, CLK, RD, RES, IN0, IN1, IN2, IN3, IN4.

Function
REQ-009 The block SHALL compute RES = IN0 + IN1*IN2 + IN3^IN4, every operation modulo 2^WIDTH, unsigned; 0^0 = 1.
REQ-010 FSM states: IDLE, MUL, POW, DONE.
REQ-011 In IDLE or DONE, ST=1 at an edge SHALL latch IN0..IN4, set P=0, counter=IN2, clear RD, enter MUL.
REQ-012 In MUL, each edge: counter==0 -> set Q=1, counter=latched IN4, enter POW; else P=P+IN1, counter-1.
REQ-013 In POW, each edge: counter==0 -> RES=IN0+P+Q, RD=1, enter DONE; else Q=low WIDTH bits of Q*IN3, counter-1.
REQ-014 Latency: RD SHALL rise exactly IN2+IN4+2 edges after the edge that sampled ST=1.
REQ-015 ST SHALL be ignored in MUL and POW; inputs SHALL be used only as latched at start.
REQ-016 In DONE, RD=1 and RES SHALL hold until restart or reset; ST held high in DONE restarts every time DONE is reached.
REQ-017 RES SHALL keep its previous value during a computation and change only on the completing edge.
REQ-018 Q*IN3 SHALL be a single-cycle multiply, truncated to WIDTH bits.

Reset
REQ-019 RST=1 at an edge SHALL force IDLE, RD=0, RES=0, P=0, Q=0, counter=0, regardless of state.
REQ-020 RST SHALL take priority over ST on the same edge.
REQ-021 Reset during MUL or POW SHALL abort the computation with no result or RD pulse.

Verification
REQ-022 IN0..IN4=2,3,3,2,3; RST high 2 edges; ST pulsed one cycle -> RD rises 8 edges later, RES=19 (0x0013), both hold.
REQ-023 IN0=5, IN1=7, IN2=0, IN3=9, IN4=0 -> RES=6, RD after 2 edges.
REQ-024 IN0=0xFFFF, IN1=1, IN2=1, IN3=2, IN4=0 -> RES=0x0001 (wrap), RD after 3 edges.
REQ-025 IN0=0, IN2=0, IN3=2, IN4=16 -> RES=0 (power overflow), RD after 18 edges.
REQ-026 RST asserted mid-MUL -> next edge RD=0, RES=0; new ST runs REQ-022 to RES=19.
REQ-027 Inputs changed and ST toggled mid-run -> result unaffected; ST in DONE clears RD next edge and recomputes with new inputs.
